arbitro_memoria_datos: RTL and testbench



---
 rtl/arbitro_memoria_datos.sv | 189 ++++++++++++++++++
 tb/tb_arbitro_memoria_datos.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_memoria_datos.sv
// Two-port arbiter sharing the data memory between the CPU load/store path (port 0)
// and the debug/loader port (port 1), with locked bursts and a registered read return.
module arbitro_memoria_datos #(
   parameter int ADDR_W    = 5,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 8,
   parameter int CPU_PRIO  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic              byte0,
   input  logic              byte1,
   input  logic              lock0,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata,
   output logic              cpu_stall,
   output logic              mem_we,
   output logic              mem_byte,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t            state_r;
   logic              gnt0_r;
   logic              gnt1_r;
   logic              rvalid0_r;
   logic              rvalid1_r;
   logic [DATA_W-1:0] rdata_r;
   logic [CNT_W-1:0]  burst_r;
   logic              last_r;

   logic              acc0_s;
   logic              acc1_s;
   logic              lock0_ok_s;
   logic              lock1_ok_s;
   logic [CNT_W-1:0]  burst_sat_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
      if (cnt == BURST_LAST) begin
         return cnt;
      end else begin
         return cnt + CNT_W'(1);
      end
   endfunction

   // A synchronous reset cycle must never issue an access, so rst gates both strobes.
   assign acc0_s      = rst & gnt0_r & req0;
   assign acc1_s      = rst & gnt1_r & req1;
   assign lock0_ok_s  = lock0 & (burst_r < BURST_LAST);
   assign lock1_ok_s  = lock1 & (burst_r < BURST_LAST);
   assign burst_sat_s = sat_inc(burst_r);

   // Ownership FSM with registered grants, burst counter and read return.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r   <= IDLE;
         gnt0_r    <= 1'b0;
         gnt1_r    <= 1'b0;
         rvalid0_r <= 1'b0;
         rvalid1_r <= 1'b0;
         rdata_r   <= {DATA_W{1'b0}};
         burst_r   <= {CNT_W{1'b0}};
         last_r    <= 1'b1;
      end else begin
         rvalid0_r <= acc0_s & ~we0;
         rvalid1_r <= acc1_s & ~we1;
         if ((acc0_s & ~we0) | (acc1_s & ~we1)) begin
            rdata_r <= mem_rdata;
         end
         case (state_r)
            IDLE: begin
               burst_r <= {CNT_W{1'b0}};
               // last_r=1 means port 1 was served last, so port 0 takes a tie.
               if (req0 & (~req1 | (CPU_PRIO != 0) | last_r)) begin
                  state_r <= OWN0;
                  gnt0_r  <= 1'b1;
                  gnt1_r  <= 1'b0;
                  last_r  <= 1'b0;
               end else if (req1) begin
                  state_r <= OWN1;
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b1;
                  last_r  <= 1'b1;
               end else begin
                  state_r <= IDLE;
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b0;
               end
            end
            OWN0: begin
               if (req0 & (~req1 | lock0_ok_s)) begin
                  burst_r <= burst_sat_s;
               end else if (req1) begin
                  state_r <= OWN1;
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b1;
                  last_r  <= 1'b1;
                  burst_r <= {CNT_W{1'b0}};
               end else begin
                  state_r <= IDLE;
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b0;
                  burst_r <= {CNT_W{1'b0}};
               end
            end
            OWN1: begin
               if (req1 & (~req0 | lock1_ok_s)) begin
                  burst_r <= burst_sat_s;
               end else if (req0) begin
                  state_r <= OWN0;
                  gnt0_r  <= 1'b1;
                  gnt1_r  <= 1'b0;
                  last_r  <= 1'b0;
                  burst_r <= {CNT_W{1'b0}};
               end else begin
                  state_r <= IDLE;
                  gnt0_r  <= 1'b0;
                  gnt1_r  <= 1'b0;
                  burst_r <= {CNT_W{1'b0}};
               end
            end
            default: begin
               state_r <= IDLE;
               gnt0_r  <= 1'b0;
               gnt1_r  <= 1'b0;
               burst_r <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   // Memory-side mux: the owner's request reaches the memory, idle drives zeros.
   always_comb begin
      mem_we    = 1'b0;
      mem_byte  = 1'b0;
      mem_addr  = {ADDR_W{1'b0}};
      mem_wdata = {DATA_W{1'b0}};
      case (state_r)
         OWN0: begin
            mem_we    = acc0_s & we0;
            mem_byte  = byte0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
         end
         OWN1: begin
            mem_we    = acc1_s & we1;
            mem_byte  = byte1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
         end
         default: begin
            mem_we    = 1'b0;
            mem_byte  = 1'b0;
            mem_addr  = {ADDR_W{1'b0}};
            mem_wdata = {DATA_W{1'b0}};
         end
      endcase
   end

   assign gnt0      = gnt0_r;
   assign gnt1      = gnt1_r;
   assign rvalid0   = rvalid0_r;
   assign rvalid1   = rvalid1_r;
   assign rdata     = rdata_r;
   assign cpu_stall = req0 & ~gnt0_r;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Bench for arbitro_memoria_datos: a round-robin and a CPU-priority instance share one
// stimulus stream and are checked every cycle against an ownership-rule model.
module tb_arbitro_memoria_datos;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int MB = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1, byte0, byte1, lock0, lock1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;

   logic [1:0]    gnt0_o, gnt1_o, rvalid0_o, rvalid1_o, stall_o, mwe_o, mbyte_o;
   logic [AW-1:0] maddr_o  [2];
   logic [DW-1:0] mwdata_o [2];
   logic [DW-1:0] mrdata_i [2];
   logic [DW-1:0] rdata_o  [2];
   logic [DW-1:0] fmem [2][32] = '{default: 32'h0};

   // model state, index 0 = round-robin instance, 1 = CPU-priority instance
   int            own [2];
   int            run [2];
   int            lastm [2];
   logic          rv0m [2];
   logic          rv1m [2];
   logic [DW-1:0] rdm [2];
   logic [DW-1:0] mm [2][32] = '{default: 32'h0};

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;
   int n;
   int held;

   always #5 clk = ~clk;

   arbitro_memoria_datos #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .CPU_PRIO(0)) dut_rr (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .byte0(byte0), .byte1(byte1), .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_o[0]), .gnt1(gnt1_o[0]), .rvalid0(rvalid0_o[0]), .rvalid1(rvalid1_o[0]),
      .rdata(rdata_o[0]), .cpu_stall(stall_o[0]), .mem_we(mwe_o[0]), .mem_byte(mbyte_o[0]),
      .mem_addr(maddr_o[0]), .mem_wdata(mwdata_o[0]), .mem_rdata(mrdata_i[0]));

   arbitro_memoria_datos #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .CPU_PRIO(1)) dut_cp (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .byte0(byte0), .byte1(byte1), .lock0(lock0), .lock1(lock1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0_o[1]), .gnt1(gnt1_o[1]), .rvalid0(rvalid0_o[1]), .rvalid1(rvalid1_o[1]),
      .rdata(rdata_o[1]), .cpu_stall(stall_o[1]), .mem_we(mwe_o[1]), .mem_byte(mbyte_o[1]),
      .mem_addr(maddr_o[1]), .mem_wdata(mwdata_o[1]), .mem_rdata(mrdata_i[1]));

   assign mrdata_i[0] = fmem[0][maddr_o[0]];
   assign mrdata_i[1] = fmem[1][maddr_o[1]];

   // Data memory seen by each instance: write on the clock edge, low byte only for byte stores.
   always @(posedge clk) begin
      for (int m = 0; m < 2; m++) begin
         if (mwe_o[m]) begin
            fmem[m][maddr_o[m]] <= mbyte_o[m] ? {fmem[m][maddr_o[m]][31:8], mwdata_o[m][7:0]}
                                               : mwdata_o[m];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_outputs(input int m);
      int            o = own[m];
      logic          e_we = 1'b0;
      logic          e_byte = 1'b0;
      logic [AW-1:0] e_addr = '0;
      logic [DW-1:0] e_wd = '0;
      if (o == 0) begin
         e_we = rst & req0 & we0; e_byte = byte0; e_addr = addr0; e_wd = wdata0;
      end else if (o == 1) begin
         e_we = rst & req1 & we1; e_byte = byte1; e_addr = addr1; e_wd = wdata1;
      end
      chk($sformatf("gnt0[%0d]", m),      32'(gnt0_o[m]),    32'(o == 0));
      chk($sformatf("gnt1[%0d]", m),      32'(gnt1_o[m]),    32'(o == 1));
      chk($sformatf("rvalid0[%0d]", m),   32'(rvalid0_o[m]), 32'(rv0m[m]));
      chk($sformatf("rvalid1[%0d]", m),   32'(rvalid1_o[m]), 32'(rv1m[m]));
      chk($sformatf("rdata[%0d]", m),     rdata_o[m],        rdm[m]);
      chk($sformatf("cpu_stall[%0d]", m), 32'(stall_o[m]),   32'(req0 && o != 0));
      chk($sformatf("mem_we[%0d]", m),    32'(mwe_o[m]),     32'(e_we));
      chk($sformatf("mem_byte[%0d]", m),  32'(mbyte_o[m]),   32'(e_byte));
      chk($sformatf("mem_addr[%0d]", m),  32'(maddr_o[m]),   32'(e_addr));
      chk($sformatf("mem_wdata[%0d]", m), mwdata_o[m],       e_wd);
   endtask

   // Advance the rule model by one clock edge using the inputs present this cycle.
   task automatic step_model(input int m);
      bit a0, a1, rqx, rqy, lkx;
      int nxt, x;
      a0 = rst && own[m] == 0 && req0;
      a1 = rst && own[m] == 1 && req1;
      if (!rst) begin
         own[m] = -1; run[m] = 0; lastm[m] = 1;
         rv0m[m] = 1'b0; rv1m[m] = 1'b0; rdm[m] = '0;
         return;
      end
      rv0m[m] = a0 && !we0;
      rv1m[m] = a1 && !we1;
      if (a0 && !we0) rdm[m] = mm[m][addr0];
      if (a1 && !we1) rdm[m] = mm[m][addr1];
      if (a0 && we0) mm[m][addr0] = byte0 ? {mm[m][addr0][31:8], wdata0[7:0]} : wdata0;
      if (a1 && we1) mm[m][addr1] = byte1 ? {mm[m][addr1][31:8], wdata1[7:0]} : wdata1;
      if (own[m] < 0) begin
         if (req0 && req1) nxt = (m == 1) ? 0 : 1 - lastm[m];
         else if (req0)    nxt = 0;
         else if (req1)    nxt = 1;
         else              nxt = -1;
      end else begin
         x   = own[m];
         rqx = (x == 0) ? req0 : req1;
         rqy = (x == 0) ? req1 : req0;
         lkx = (x == 0) ? lock0 : lock1;
         if (!rqx)                          nxt = rqy ? 1 - x : -1;
         else if (!rqy)                     nxt = x;
         else if (lkx && run[m] + 1 < MB)   nxt = x;
         else                               nxt = 1 - x;
      end
      if (nxt != own[m]) begin
         run[m] = 0;
         if (nxt >= 0) lastm[m] = nxt;
      end else if (a0 || a1) begin
         run[m] = run[m] + 1;
      end
      own[m] = nxt;
   endtask

   task automatic tick();
      @(negedge clk);
      if (chk_en) begin
         check_outputs(0);
         check_outputs(1);
      end
      step_model(0);
      step_model(1);
      @(posedge clk);
      #1;
   endtask

   // Counts consecutive port-1 grant cycles (bounded), writing addr i with 0x1000+i.
   task automatic count_burst(output int cnt);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         if (gnt1_o[0] !== 1'b1) break;
         cnt++;
         tick();
         addr1  = 5'(i + 1);
         wdata1 = 32'h0000_1000 + 32'(i + 1);
      end
   endtask

   initial begin
      for (int m = 0; m < 2; m++) begin
         own[m] = -1; run[m] = 0; lastm[m] = 1;
         rv0m[m] = 1'b0; rv1m[m] = 1'b0; rdm[m] = '0;
      end
      rst = 1'b0; req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
      byte0 = 1'b0; byte1 = 1'b0; lock0 = 1'b0; lock1 = 1'b0;
      addr0 = 5'd0; addr1 = 5'd0; wdata0 = 32'h0; wdata1 = 32'h0;

      // reset held two edges with both requesting
      tick();
      chk_en = 1'b1;
      tick();
      chk("rst_gnt0", 32'(gnt0_o[0]), 32'd0);
      chk("rst_gnt1", 32'(gnt1_o[0]), 32'd0);
      chk("rst_mem_we", 32'(mwe_o[0]), 32'd0);
      chk("rst_rvalid0", 32'(rvalid0_o[0]), 32'd0);
      chk("rst_rdata", rdata_o[0], 32'h0);

      // release: tie goes to port 0 on both instances
      rst = 1'b1;
      tick();
      chk("rel_gnt0_rr", 32'(gnt0_o[0]), 32'd1);
      chk("rel_gnt0_cp", 32'(gnt0_o[1]), 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      tick();

      // single write then read on port 0
      req0 = 1'b1; we0 = 1'b1; addr0 = 5'd5; wdata0 = 32'hDEAD_BEEF;
      tick();
      chk("wr_mem_we", 32'(mwe_o[0]), 32'd1);
      chk("wr_stall", 32'(stall_o[0]), 32'd0);
      tick();
      we0 = 1'b0;
      #1;
      chk("rd_mem_we", 32'(mwe_o[0]), 32'd0);
      tick();
      chk("rd_rvalid0", 32'(rvalid0_o[0]), 32'd1);
      chk("rd_rdata", rdata_o[0], 32'hDEAD_BEEF);
      req0 = 1'b0;
      tick();
      chk("rd_rvalid0_end", 32'(rvalid0_o[0]), 32'd0);
      chk("rd_gnt0_end", 32'(gnt0_o[0]), 32'd0);

      // continuous contention, both unlocked
      req0 = 1'b1; req1 = 1'b1; addr0 = 5'd5; addr1 = 5'd5;
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("rr_gnt1_%0d", k),  32'(gnt1_o[0]),  32'(k % 2 == 0));
         chk($sformatf("rr_stall_%0d", k), 32'(stall_o[0]), 32'(k % 2 == 0));
         chk($sformatf("cp_gnt0_%0d", k),  32'(gnt0_o[1]),  32'(k % 2 == 0));
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      tick();

      // locked port-1 burst with port 0 pending
      addr0 = 5'd3; req1 = 1'b1; lock1 = 1'b1; we1 = 1'b1; addr1 = 5'd0; wdata1 = 32'h0000_1000;
      tick();
      req0 = 1'b1;
      count_burst(n);
      chk("burst_len", 32'(n), 32'd8);
      chk("burst_handover_rr", 32'(gnt0_o[0]), 32'd1);
      chk("burst_handover_cp", 32'(gnt0_o[1]), 32'd1);
      tick();
      chk("burst_rd_rvalid0", 32'(rvalid0_o[0]), 32'd1);
      chk("burst_rd_rdata", rdata_o[0], 32'h0000_1003);

      // uncontended locked owner keeps the grant
      req0 = 1'b0; byte1 = 1'b1;
      held = 0;
      for (int i = 0; i < 12; i++) begin
         if (gnt1_o[0] === 1'b1) held++;
         addr1 = 5'(20 + (i % 4));
         wdata1 = 32'h0000_B000 + 32'(i);
         tick();
      end
      chk("hold_len", 32'(held), 32'd12);

      // reset arriving on the third access of a locked write burst
      req1 = 1'b0; byte1 = 1'b0;
      tick();
      req1 = 1'b1; addr1 = 5'd10; wdata1 = 32'hCAFE_00A0;
      tick();
      tick();
      addr1 = 5'd11; wdata1 = 32'hCAFE_00A1;
      tick();
      addr1 = 5'd12; wdata1 = 32'hCAFE_00A2; rst = 1'b0;
      #1;
      chk("midrst_mem_we_rr", 32'(mwe_o[0]), 32'd0);
      chk("midrst_mem_we_cp", 32'(mwe_o[1]), 32'd0);
      tick();
      chk("midrst_gnt1", 32'(gnt1_o[0]), 32'd0);
      chk("midrst_rvalid1", 32'(rvalid1_o[0]), 32'd0);
      rst = 1'b1;
      tick();
      req0 = 1'b1; addr0 = 5'd11; we0 = 1'b0;
      count_burst(n);
      chk("burst_len_after_rst", 32'(n), 32'd8);
      tick();
      chk("post_rst_rdata", rdata_o[0], 32'hCAFE_00A1);
      req0 = 1'b0; req1 = 1'b0; lock1 = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
